uart_tx_sched: RTL and testbench

Round-robin scheduler that shares the single UART transmit path (`tx_data_valid`/`tx_data` of the UART top) between `N_REQ` byte-stream requesters. Once a requester is granted, it keeps the transmitter for a whole message, delimited by a `last` flag. The transmitter has no ready/busy output, so the block paces bytes with its own byte-period counter derived from the baud parameters. It sits between the application requesters and the UART top, and drives the UART's TX inputs directly.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/uart_tx_sched.sv | 135 +++++++++++++
 tb/tb_uart_tx_sched.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
// Holds the state encoding and the constant helpers used to size the byte timer.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } sched_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // One UART frame is 10 bits plus the idle gap, measured in clock cycles.
    function automatic int byte_cycles(input int clk_per, input int band_rate, input int gap_bits);
        return (clk_per / band_rate) * (10 + gap_bits);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first asserted request at or above ptr,
// wrapping modulo N_REQ.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!valid && req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
            idx = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmit path between N_REQ requesters.
// An owner keeps the transmitter for a whole message; bytes are paced by a local timer.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int CLK_PER   = 50_000_000,
    parameter int BAND_RATE = 9600,
    parameter int GAP_BITS  = 1,
    parameter int N_REQ     = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          req,
    input  logic [8*N_REQ-1:0]        req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ack,
    output logic                      tx_data_valid,
    output logic [7:0]                tx_data,
    output logic [clog2(N_REQ)-1:0]   grant_id,
    output logic                      busy,
    output logic                      abort
);

    localparam int IDX_W    = clog2(N_REQ);
    localparam int BYTE_CYC = byte_cycles(CLK_PER, BAND_RATE, GAP_BITS);
    localparam int CNT_W    = clog2(BYTE_CYC);
    localparam logic [CNT_W-1:0] WAIT_END = CNT_W'(BYTE_CYC - 2);
    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(BYTE_CYC - 1);

    sched_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] grant_d;
    logic             last_q, last_d;
    logic [7:0]       data_q, data_d;
    logic [IDX_W-1:0] arb_grant;
    logic             arb_valid;
    logic             owner_req;
    logic [7:0]       owner_byte;
    logic [IDX_W-1:0] next_ptr;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    assign owner_req  = req[grant_id];
    assign owner_byte = req_data[{grant_id, 3'b000} +: 8];
    assign next_ptr   = (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            grant_id <= '0;
            last_q   <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            grant_id <= grant_d;
            last_q   <= last_d;
            data_q   <= data_d;
        end
    end

    // The owner is only re-examined at the end of a byte period or while stalled,
    // so other requesters cannot preempt a message in flight.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        grant_d       = grant_id;
        last_d        = last_q;
        data_d        = data_q;
        tx_data_valid = 1'b0;
        tx_data       = data_q;
        req_ack       = '0;
        abort         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_data_valid = 1'b1;
                tx_data       = owner_byte;
                data_d        = owner_byte;
                req_ack       = N_REQ'(1) << grant_id;
                last_d        = req_last[grant_id];
                cnt_d         = '0;
                state_d       = WAIT;
            end
            WAIT: begin
                if (cnt_q == WAIT_END) begin
                    if (last_q) begin
                        ptr_d   = next_ptr;
                        state_d = IDLE;
                    end else if (owner_req) begin
                        state_d = SEND;
                    end else begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (owner_req) begin
                    state_d = SEND;
                end else if (cnt_q == HOLD_END) begin
                    abort   = 1'b1;
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: byte-stream requesters driven from message queues,
// transmissions scored against a cycle-level model of the scheduling rules.
module tb_uart_tx_sched;

    localparam int N        = 4;
    localparam int BYTE_CYC = 110;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ack;
    logic           tx_data_valid;
    logic [7:0]     tx_data;
    logic [1:0]     grant_id;
    logic           busy;
    logic           abort;

    always #5 clk_i = ~clk_i;

    uart_tx_sched #(
        .CLK_PER   (1_000_000),
        .BAND_RATE (100_000),
        .GAP_BITS  (1),
        .N_REQ     (N)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req           (req),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ack       (req_ack),
        .tx_data_valid (tx_data_valid),
        .tx_data       (tx_data),
        .grant_id      (grant_id),
        .busy          (busy),
        .abort         (abort)
    );

    typedef struct {
        int cyc;
        int data;
        int owner;
        int ack;
    } pulse_t;

    pulse_t     act_q[$];
    pulse_t     exp_q[$];
    int         abort_q[$];
    bit         busy_hist[int];
    logic [8:0] msg_q[N][$];
    logic [8:0] model_q[N][$];
    bit         stall[N];
    bit         stall_next[N];
    logic [N-1:0] ack_seen;
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    int         ptr_m  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Each requester presents the head of its queue unless it is deliberately stalled.
    task automatic applyStimulus();
        logic [8:0] head;
        for (int i = 0; i < N; i++) begin
            if (msg_q[i].size() > 0) begin
                head                = msg_q[i][0];
                req[i]              = !stall[i];
                req_data[8*i +: 8]  = head[7:0];
                req_last[i]         = head[8];
            end else begin
                req[i]              = 1'b0;
                req_data[8*i +: 8]  = 8'h00;
                req_last[i]         = 1'b0;
            end
        end
    endtask

    task automatic add_byte(input int i, input logic [7:0] d, input logic last);
        msg_q[i].push_back({last, d});
    endtask

    // Sample at the falling edge, then advance requesters just after the rising edge.
    task automatic tick();
        pulse_t p;
        @(negedge clk_i);
        busy_hist[cyc] = busy;
        if (abort) abort_q.push_back(cyc);
        ack_seen = req_ack;
        if (tx_data_valid) begin
            p.cyc   = cyc;
            p.data  = int'(tx_data);
            p.owner = int'(grant_id);
            p.ack   = int'(req_ack);
            act_q.push_back(p);
        end
        @(posedge clk_i);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (ack_seen[i] && msg_q[i].size() > 0) begin
                void'(msg_q[i].pop_front());
                if (stall_next[i]) begin
                    stall[i]      = 1'b1;
                    stall_next[i] = 1'b0;
                end
            end
        end
        applyStimulus();
    endtask

    task automatic run_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic wait_pulse(input int budget, output int pcyc);
        int n;
        int waited;
        n      = act_q.size();
        waited = 0;
        while (act_q.size() == n && waited < budget) begin
            tick();
            waited++;
        end
        checkOutput("pulse_seen", act_q.size(), n + 1);
        pcyc = (act_q.size() > n) ? act_q[n].cyc : cyc;
    endtask

    task automatic push_expected(input int c, input int d, input int o);
        pulse_t p;
        p.cyc   = c;
        p.data  = d;
        p.owner = o;
        p.ack   = 1 << o;
        exp_q.push_back(p);
    endtask

    // Reference: with every queue loaded at t0 and held, messages go out whole in
    // round-robin order; bytes BYTE_CYC apart, one extra idle cycle between messages.
    task automatic build_expected(input int t0, output int t_end);
        int         t;
        int         o;
        bit         done;
        logic [8:0] b;
        for (int i = 0; i < N; i++) model_q[i] = msg_q[i];
        t     = t0 + 1;
        t_end = t0;
        done  = 1'b0;
        while (!done) begin
            o = -1;
            for (int k = 0; k < N; k++) begin
                if (o < 0 && model_q[(ptr_m + k) % N].size() > 0) o = (ptr_m + k) % N;
            end
            if (o < 0) begin
                done = 1'b1;
            end else begin
                b = 9'h000;
                while (!b[8] && model_q[o].size() > 0) begin
                    b = model_q[o].pop_front();
                    push_expected(t, int'(b[7:0]), o);
                    t_end = t;
                    t     = t + BYTE_CYC;
                end
                t     = t + 1;
                ptr_m = (o + 1) % N;
            end
        end
    endtask

    task automatic compare_pulses(input string tag);
        checkOutput({tag, "_count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checkOutput({tag, "_cycle"}, act_q[i].cyc,   exp_q[i].cyc);
            checkOutput({tag, "_data"},  act_q[i].data,  exp_q[i].data);
            checkOutput({tag, "_grant"}, act_q[i].owner, exp_q[i].owner);
            checkOutput({tag, "_ack"},   act_q[i].ack,   exp_q[i].ack);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        ptr_m = 0;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         t0, t_end, p, k, d, nbusy, nm, len;
        bit         any;
        logic [7:0] b1, b2, c;

        req      = '0;
        req_data = '0;
        req_last = '0;
        ack_seen = '0;
        for (int i = 0; i < N; i++) begin
            stall[i]      = 1'b0;
            stall_next[i] = 1'b0;
        end

        // Reset values, then a long quiet period.
        repeat (3) tick();
        checkOutput("rst_valid", tx_data_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_tx_data", tx_data, 0);
        checkOutput("rst_ack", req_ack, 0);
        rst_i = 1'b0;
        t0 = cyc;
        repeat (200) tick();
        nbusy = 0;
        for (int i = t0; i < cyc; i++) if (busy_hist[i]) nbusy++;
        checkOutput("idle_pulses", act_q.size(), 0);
        checkOutput("idle_busy", nbusy, 0);
        checkOutput("idle_abort", abort_q.size(), 0);
        checkOutput("idle_grant", grant_id, 0);
        checkOutput("idle_tx_data", tx_data, 0);

        // Requester 2: three-byte message.
        add_byte(2, 8'hA1, 1'b0);
        add_byte(2, 8'hA2, 1'b0);
        add_byte(2, 8'hA3, 1'b1);
        applyStimulus();
        t0 = cyc;
        build_expected(t0, t_end);
        run_until(t_end + 112);
        compare_pulses("msg3");
        checkOutput("msg3_busy_last", busy_hist[t_end + 109], 1);
        checkOutput("msg3_busy_drop", busy_hist[t_end + 110], 0);
        checkOutput("msg3_tx_hold", tx_data, 8'hA3);
        checkOutput("msg3_abort", abort_q.size(), 0);

        // Three simultaneous single-byte messages from ptr = 0.
        apply_reset();
        add_byte(0, 8'h10, 1'b1);
        add_byte(1, 8'h11, 1'b1);
        add_byte(3, 8'h13, 1'b1);
        applyStimulus();
        t0 = cyc;
        build_expected(t0, t_end);
        run_until(t_end + 112);
        compare_pulses("rr3");

        // Requester 1 stalls after its first byte and resumes inside HOLD.
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        add_byte(1, b1, 1'b0);
        add_byte(1, b2, 1'b1);
        stall_next[1] = 1'b1;
        applyStimulus();
        t0 = cyc;
        wait_pulse(10, p);
        checkOutput("hold_first_cycle", p, t0 + 1);
        d = $urandom_range(0, 100);
        run_until(p + 110 + d);
        stall[1] = 1'b0;
        applyStimulus();
        k = cyc;
        run_until(k + 1 + 112);
        push_expected(p, b1, 1);
        push_expected(k + 1, b2, 1);
        compare_pulses("hold");
        checkOutput("hold_busy", busy_hist[p + 110], 1);
        checkOutput("hold_busy_drop", busy_hist[k + 111], 0);
        checkOutput("hold_no_abort", abort_q.size(), 0);
        ptr_m = 2;

        // Requester 1 stalls for good; requester 2 waits behind it.
        b1 = 8'($urandom);
        c  = 8'($urandom);
        add_byte(1, b1, 1'b0);
        add_byte(1, 8'h5A, 1'b1);
        stall_next[1] = 1'b1;
        applyStimulus();
        t0 = cyc;
        wait_pulse(10, p);
        checkOutput("abort_first_cycle", p, t0 + 1);
        add_byte(2, c, 1'b1);
        applyStimulus();
        run_until(p + 221 + 112);
        push_expected(p, b1, 1);
        push_expected(p + 221, c, 2);
        compare_pulses("abort");
        checkOutput("abort_count", abort_q.size(), 1);
        checkOutput("abort_cycle", (abort_q.size() > 0) ? abort_q[0] : -1, p + 219);
        checkOutput("abort_busy_hold", busy_hist[p + 219], 1);
        checkOutput("abort_busy_drop", busy_hist[p + 220], 0);
        abort_q.delete();
        msg_q[1].delete();
        stall[1] = 1'b0;
        applyStimulus();
        ptr_m = 3;

        // Randomized batches of messages.
        for (int r = 0; r < 4; r++) begin
            any = 1'b0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) != 0) begin
                    nm = $urandom_range(1, 2);
                    for (int m = 0; m < nm; m++) begin
                        len = $urandom_range(1, 3);
                        for (int j = 0; j < len; j++) add_byte(i, 8'($urandom), j == len - 1);
                    end
                    any = 1'b1;
                end
            end
            if (!any) add_byte(r % N, 8'($urandom), 1'b1);
            applyStimulus();
            t0 = cyc;
            build_expected(t0, t_end);
            run_until(t_end + 112);
            compare_pulses("rand");
            checkOutput("rand_abort", abort_q.size(), 0);
            checkOutput("rand_busy_drop", busy_hist[t_end + 110], 0);
        end

        // Reset in the middle of WAIT with requester 0 still pending.
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        add_byte(0, b1, 1'b0);
        add_byte(0, b2, 1'b1);
        applyStimulus();
        wait_pulse(10, p);
        run_until(p + 40);
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_valid", tx_data_valid, 0);
        checkOutput("midrst_tx_data", tx_data, 0);
        checkOutput("midrst_grant", grant_id, 0);
        checkOutput("midrst_ack", req_ack, 0);
        checkOutput("midrst_abort", abort, 0);
        repeat (2) tick();
        rst_i = 1'b0;
        ptr_m = 0;
        k = cyc;
        run_until(k + 1 + 112);
        push_expected(p, b1, 0);
        push_expected(k + 1, b2, 0);
        compare_pulses("midrst");
        checkOutput("midrst_no_abort", abort_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
